// File: rtl/fpu_dp_adder.sv
// fpu_dp_adder: IEEE-754 binary64 adder with round-to-nearest-even and a single
// output register stage; flags overflow past max finite and nonzero tiny results.
module fpu_dp_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             out_valid
);

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic [63:0] op      [2];
  logic        sgn_op  [2];
  logic [10:0] exp_op  [2];
  logic [51:0] frac_op [2];
  logic        nan_op  [2];
  logic        inf_op  [2];
  logic [52:0] man_op  [2];
  logic [10:0] eexp_op [2];

  assign op[0] = a;
  assign op[1] = b;

  // Subnormals carry a hidden 0 and share the effective exponent of 1.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign sgn_op[gi]  = op[gi][63];
      assign exp_op[gi]  = op[gi][62:52];
      assign frac_op[gi] = op[gi][51:0];
      assign nan_op[gi]  = (exp_op[gi] == 11'h7FF) && (frac_op[gi] != 52'd0);
      assign inf_op[gi]  = (exp_op[gi] == 11'h7FF) && (frac_op[gi] == 52'd0);
      assign man_op[gi]  = {exp_op[gi] != 11'd0, frac_op[gi]};
      assign eexp_op[gi] = (exp_op[gi] == 11'd0) ? 11'd1 : exp_op[gi];
    end
  endgenerate

  function automatic logic [5:0] lzc56(input logic [55:0] v);
    lzc56 = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (v[i]) lzc56 = 6'(55 - i);
    end
  endfunction

  logic        a_ge_b;
  logic        sign_x;
  logic        sign_y;
  logic [10:0] exp_x;
  logic [10:0] exp_y;
  logic [52:0] man_x;
  logic [52:0] man_y;
  logic [10:0] diff;

  assign a_ge_b = (a[62:0] >= b[62:0]);
  assign sign_x = a_ge_b ? sgn_op[0]  : sgn_op[1];
  assign sign_y = a_ge_b ? sgn_op[1]  : sgn_op[0];
  assign exp_x  = a_ge_b ? eexp_op[0] : eexp_op[1];
  assign exp_y  = a_ge_b ? eexp_op[1] : eexp_op[0];
  assign man_x  = a_ge_b ? man_op[0]  : man_op[1];
  assign man_y  = a_ge_b ? man_op[1]  : man_op[0];
  assign diff   = exp_x - exp_y;

  // Significands carry three extra bits: guard, round and a sticky LSB.
  logic [55:0] x_ext;
  logic [55:0] y_ext;
  logic [55:0] y_shift;
  logic [55:0] y_al;
  logic        y_lost;

  assign x_ext = {man_x, 3'b000};
  assign y_ext = {man_y, 3'b000};

  always_comb begin
    y_shift = '0;
    y_lost  = 1'b0;
    if (diff >= 11'd56) begin
      y_al = {55'd0, |man_y};
    end else begin
      y_shift = y_ext >> diff;
      y_lost  = |(y_ext & ~({56{1'b1}} << diff));
      y_al    = {y_shift[55:1], y_shift[0] | y_lost};
    end
  end

  logic        eff_sub;
  logic [56:0] sum;
  logic        is_zero;

  assign eff_sub = sign_x ^ sign_y;
  assign sum     = eff_sub ? ({1'b0, x_ext} - {1'b0, y_al})
                           : ({1'b0, x_ext} + {1'b0, y_al});
  assign is_zero = (sum == 57'd0);

  logic [5:0]  lz;
  logic [10:0] max_shift;
  logic [10:0] shift;
  logic [55:0] norm;
  logic [11:0] norm_exp;

  assign lz        = lzc56(sum[55:0]);
  assign max_shift = exp_x - 11'd1;

  // Left normalisation stops at exponent 1 so tiny results stay subnormal.
  always_comb begin
    norm     = '0;
    norm_exp = '0;
    shift    = '0;
    if (sum[56]) begin
      norm     = {sum[56:2], |sum[1:0]};
      norm_exp = {1'b0, exp_x} + 12'd1;
    end else begin
      shift    = ({5'd0, lz} > max_shift) ? max_shift : {5'd0, lz};
      norm     = sum[55:0] << shift;
      norm_exp = {1'b0, exp_x - shift};
    end
  end

  logic [52:0] mant;
  logic        rnd_up;
  logic [53:0] mant_r;
  logic [11:0] exp_out;
  logic [51:0] frac_out;
  logic        tiny;

  assign mant   = norm[55:3];
  assign rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign mant_r = {1'b0, mant} + {53'd0, rnd_up};
  assign tiny   = ~sum[56] & ~norm[55];

  // A hidden bit appearing after rounding promotes a subnormal to exponent 1.
  always_comb begin
    if (mant_r[53]) begin
      exp_out  = norm_exp + 12'd1;
      frac_out = mant_r[52:1];
    end else begin
      exp_out  = mant_r[52] ? norm_exp : 12'd0;
      frac_out = mant_r[51:0];
    end
  end

  logic [63:0] result_next;
  logic        overflow_next;
  logic        underflow_next;

  always_comb begin
    result_next    = '0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (nan_op[0] || nan_op[1] || (inf_op[0] && inf_op[1] && (sgn_op[0] != sgn_op[1]))) begin
      result_next = QNAN;
    end else if (inf_op[0]) begin
      result_next = a;
    end else if (inf_op[1]) begin
      result_next = b;
    end else if (is_zero) begin
      result_next = {sgn_op[0] & sgn_op[1], 63'd0};
    end else if (exp_out >= 12'd2047) begin
      result_next   = {sign_x, 11'h7FF, 52'd0};
      overflow_next = 1'b1;
    end else begin
      result_next    = {sign_x, exp_out[10:0], frac_out};
      underflow_next = tiny;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      result    <= result_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_fpu_dp_adder.sv
// tb_fpu_dp_adder: scoreboard bench; expected sums come from host real addition
// with the IEEE special-value rules applied on top.
module tb_fpu_dp_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        in_valid = 1'b0;
  logic [63:0] result;
  logic        overflow;
  logic        underflow;
  logic        out_valid;

  fpu_dp_adder #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .result(result), .overflow(overflow), .underflow(underflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        ov;
    logic        un;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          txn = 0;
  int          issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic is_nan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] == 52'd0);
  endfunction

  task automatic model(input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output logic ov, output logic un);
    ov = 1'b0;
    un = 1'b0;
    if (is_nan(x) || is_nan(y)) r = 64'h7FF8000000000000;
    else if (is_inf(x) && is_inf(y)) r = (x[63] == y[63]) ? x : 64'h7FF8000000000000;
    else if (is_inf(x)) r = x;
    else if (is_inf(y)) r = y;
    else begin
      r  = $realtobits($bitstoreal(x) + $bitstoreal(y));
      ov = (r[62:0] == {11'h7FF, 52'd0});
      un = (r[62:52] == 11'd0) && (r[51:0] != 52'd0);
    end
  endtask

  task automatic issue(input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] r, input logic ov, input logic un);
    exp_t e;
    @(posedge clk);
    #1;
    a = x;
    b = y;
    in_valid = 1'b1;
    e.a = x; e.b = y; e.r = r; e.ov = ov; e.un = un; e.cyc = cyc;
    sb_q.push_back(e);
    issued++;
  endtask

  task automatic issue_model(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    logic        ov;
    logic        un;
    model(x, y, r, ov, un);
    issue(x, y, r, ov, un);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] rand_op(input int cls, input logic [63:0] other);
    int          e;
    logic [63:0] sp [6];
    sp[0] = 64'h0000000000000000; sp[1] = 64'h8000000000000000;
    sp[2] = 64'h7FF0000000000000; sp[3] = 64'hFFF0000000000000;
    sp[4] = 64'h7FF8000000000000; sp[5] = 64'hFFF0000000000123;
    case (cls)
      1: begin
        e = int'(other[62:52]) + int'($urandom_range(0, 4)) - 2;
        if (e < 1) e = 1;
        if (e > 2046) e = 2046;
        return {1'($urandom), 11'(e), 20'($urandom), 32'($urandom)};
      end
      2: return {1'($urandom), 11'($urandom_range(0, 2)), 20'($urandom), 32'($urandom)};
      3: return {1'($urandom), 11'(2046 - $urandom_range(0, 1)), 20'($urandom), 32'($urandom)};
      4: return sp[$urandom_range(0, 5)];
      5: return {~other[63], other[62:0] ^ 63'($urandom_range(0, 3))};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: out_valid=1 with no pending operands, required 0");
      end else begin
        mon_e = sb_q.pop_front();
        check("latency", 64'(cyc - mon_e.cyc), 64'd1);
        check("result", result, mon_e.r);
        check("overflow", {63'd0, overflow}, {63'd0, mon_e.ov});
        check("underflow", {63'd0, underflow}, {63'd0, mon_e.un});
        txn++;
        $display("txn %0d: %h + %h -> %h ovf=%0b unf=%0b", txn, mon_e.a, mon_e.b,
                 result, overflow, underflow);
      end
    end
  end

  logic [63:0] dir_a [13] = '{64'h3FF0000000000000, 64'h4010CCCCCCCCCCCD, 64'h7FEFFFFFFFFFFFFF,
                               64'h0000000000000001, 64'h3FF0000000000000, 64'h3FF0000000000000,
                               64'h7FF0000000000000, 64'h7FF0000000000000, 64'h8000000000000000,
                               64'h0000000000000000, 64'h7FF0000000000001, 64'h000FFFFFFFFFFFFF,
                               64'hFFF0000000000000};
  logic [63:0] dir_b [13] = '{64'h4000000000000000, 64'h400999999999999A, 64'h7FEFFFFFFFFFFFFF,
                               64'h0000000000000001, 64'hBFF0000000000000, 64'h3CA0000000000000,
                               64'hFFF0000000000000, 64'h3FF0000000000000, 64'h8000000000000000,
                               64'h8000000000000000, 64'h3FF0000000000000, 64'h0000000000000001,
                               64'hFFF0000000000000};
  logic [63:0] dir_r [13] = '{64'h4008000000000000, 64'h401D99999999999A, 64'h7FF0000000000000,
                               64'h0000000000000002, 64'h0000000000000000, 64'h3FF0000000000000,
                               64'h7FF8000000000000, 64'h7FF0000000000000, 64'h8000000000000000,
                               64'h0000000000000000, 64'h7FF8000000000000, 64'h0010000000000000,
                               64'hFFF0000000000000};
  logic        dir_ov [13] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic        dir_un [13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  real sw_a [4] = '{-6.4, 2234.0132, 124054.4312345, 121.3232};
  real sw_b [4] = '{-0.5, -1235.3412, -9213743.123655343, -123.1231};

  initial begin
    logic [63:0] x;
    logic [63:0] y;
    int          wait_cycles;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_result", result, 64'h0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // In-flight result must be discarded by an asynchronous reset between edges.
    @(posedge clk);
    #1;
    a = 64'h7FEFFFFFFFFFFFFF;
    b = 64'h3FF0000000000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_result", result, 64'h0);
    check("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_reset_flags", {62'd0, overflow, underflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) issue(dir_a[i], dir_b[i], dir_r[i], dir_ov[i], dir_un[i]);
    idle();
    for (int i = 0; i < 4; i++) issue_model($realtobits(sw_a[i]), $realtobits(sw_b[i]));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      x = rand_op(int'($urandom_range(0, 3)), 64'h3FF0000000000000);
      y = rand_op(int'($urandom_range(0, 5)), x);
      if ($urandom_range(0, 1) == 1) issue_model(y, x);
      else issue_model(x, y);
    end
    idle();

    wait_cycles = 0;
    while (sb_q.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d transactions still pending, required 0", sb_q.size());
    end
    check("txn_count", 64'(txn), 64'(issued));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
